id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/dlx_pkg.sv | 71 +++++++
 rtl/alu_ctrl_dec.sv | 85 ++++++++
 rtl/id_ex_stage.sv | 98 +++++++++
 tb/tb_id_ex_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX decode constants: opcode/func encodings, ALU select codes and operand classes.
package dlx_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDUI = 6'h09;
  localparam logic [5:0] OP_SUBI  = 6'h0A;
  localparam logic [5:0] OP_SUBUI = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_SLLI  = 6'h14;
  localparam logic [5:0] OP_SRLI  = 6'h16;
  localparam logic [5:0] OP_SRAI  = 6'h17;
  localparam logic [5:0] OP_SEQI  = 6'h18;
  localparam logic [5:0] OP_SNEI  = 6'h19;
  localparam logic [5:0] OP_SLTI  = 6'h1A;
  localparam logic [5:0] OP_SGTI  = 6'h1B;
  localparam logic [5:0] OP_SLEI  = 6'h1C;
  localparam logic [5:0] OP_SGEI  = 6'h1D;

  localparam logic [5:0] FN_SLL  = 6'h04;
  localparam logic [5:0] FN_SRL  = 6'h06;
  localparam logic [5:0] FN_SRA  = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SEQ  = 6'h28;
  localparam logic [5:0] FN_SNE  = 6'h29;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SGT  = 6'h2B;
  localparam logic [5:0] FN_SLE  = 6'h2C;
  localparam logic [5:0] FN_SGE  = 6'h2D;

  typedef enum logic [5:0] {
    SEL_AND = 6'b000000,
    SEL_OR  = 6'b000001,
    SEL_XOR = 6'b000010,
    SEL_SRA = 6'b000100,
    SEL_SRL = 6'b000101,
    SEL_SLL = 6'b000110,
    SEL_ADD = 6'b100000,
    SEL_SEQ = 6'b110000,
    SEL_SNE = 6'b110001,
    SEL_SLT = 6'b110010,
    SEL_SGT = 6'b110011,
    SEL_SLE = 6'b110100,
    SEL_SGE = 6'b110110,
    SEL_SUB = 6'b111000
  } alu_sel_e;

  typedef enum logic [1:0] {
    OPND_LOGIC,
    OPND_SHIFT,
    OPND_ARITH
  } opnd_e;

  // How the second operand is formed depends only on the ALU operation.
  function automatic opnd_e opnd_class(alu_sel_e s);
    case (s)
      SEL_AND, SEL_OR, SEL_XOR:  return OPND_LOGIC;
      SEL_SRA, SEL_SRL, SEL_SLL: return OPND_SHIFT;
      default:                   return OPND_ARITH;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational DLX decode: opcode/func to ALU select, operand formation and illegal flag.
module alu_ctrl_dec
  import dlx_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  func_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [15:0] imm16_i,
  output logic [5:0]  sel_o,
  output logic [31:0] in1_o,
  output logic [31:0] in2_o,
  output logic        illegal_o
);

  alu_sel_e    op_e;
  logic        hit;
  logic        rtype;
  opnd_e       cls;
  logic [31:0] imm_ext;
  logic [31:0] opnd2;

  always_comb begin
    op_e  = SEL_AND;
    hit   = 1'b1;
    rtype = (opcode_i == OP_RTYPE);
    if (rtype) begin
      case (func_i)
        FN_ADD, FN_ADDU: op_e = SEL_ADD;
        FN_SUB, FN_SUBU: op_e = SEL_SUB;
        FN_AND:          op_e = SEL_AND;
        FN_OR:           op_e = SEL_OR;
        FN_XOR:          op_e = SEL_XOR;
        FN_SLL:          op_e = SEL_SLL;
        FN_SRL:          op_e = SEL_SRL;
        FN_SRA:          op_e = SEL_SRA;
        FN_SEQ:          op_e = SEL_SEQ;
        FN_SNE:          op_e = SEL_SNE;
        FN_SLT:          op_e = SEL_SLT;
        FN_SGT:          op_e = SEL_SGT;
        FN_SLE:          op_e = SEL_SLE;
        FN_SGE:          op_e = SEL_SGE;
        default:         hit  = 1'b0;
      endcase
    end else begin
      case (opcode_i)
        OP_ADDI, OP_ADDUI: op_e = SEL_ADD;
        OP_SUBI, OP_SUBUI: op_e = SEL_SUB;
        OP_ANDI:           op_e = SEL_AND;
        OP_ORI:            op_e = SEL_OR;
        OP_XORI:           op_e = SEL_XOR;
        OP_SLLI:           op_e = SEL_SLL;
        OP_SRLI:           op_e = SEL_SRL;
        OP_SRAI:           op_e = SEL_SRA;
        OP_SEQI:           op_e = SEL_SEQ;
        OP_SNEI:           op_e = SEL_SNE;
        OP_SLTI:           op_e = SEL_SLT;
        OP_SGTI:           op_e = SEL_SGT;
        OP_SLEI:           op_e = SEL_SLE;
        OP_SGEI:           op_e = SEL_SGE;
        default:           hit  = 1'b0;
      endcase
    end

    cls = opnd_class(op_e);
    case (cls)
      OPND_LOGIC: imm_ext = {16'b0, imm16_i};
      OPND_SHIFT: imm_ext = {27'b0, imm16_i[4:0]};
      default:    imm_ext = {{16{imm16_i[15]}}, imm16_i};
    endcase

    if (rtype) begin
      opnd2 = (cls == OPND_SHIFT) ? {27'b0, rs2_data_i[4:0]} : rs2_data_i;
    end else begin
      opnd2 = imm_ext;
    end

    // Unmapped encodings present a zeroed payload so the ALU sees a harmless AND of 0,0.
    sel_o     = hit ? op_e : '0;
    in1_o     = hit ? rs1_data_i : '0;
    in2_o     = hit ? opnd2 : '0;
    illegal_o = !hit;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake and flush; decode lives in alu_ctrl_dec.
module id_ex_stage
  import dlx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [15:0] imm16,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic        sel0,
  output logic        sel1,
  output logic        sel2,
  output logic        sel3,
  output logic        sel4,
  output logic        sel5,
  output logic        illegal
);

  logic [5:0]  dec_sel;
  logic [31:0] dec_in1;
  logic [31:0] dec_in2;
  logic        dec_illegal;

  logic        valid_q, valid_d;
  logic        illegal_q, illegal_d;
  logic [31:0] in1_q, in1_d;
  logic [31:0] in2_q, in2_d;
  logic [5:0]  sel_q, sel_d;
  logic        xfer;

  alu_ctrl_dec u_dec (
    .opcode_i   (opcode),
    .func_i     (func),
    .rs1_data_i (rs1_data),
    .rs2_data_i (rs2_data),
    .imm16_i    (imm16),
    .sel_o      (dec_sel),
    .in1_o      (dec_in1),
    .in2_o      (dec_in2),
    .illegal_o  (dec_illegal)
  );

  assign in_ready = (!valid_q || out_ready) && !flush;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    valid_d   = valid_q;
    illegal_d = illegal_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    sel_d     = sel_q;
    // flush already forces in_ready low, so it can never coincide with a load.
    if (flush) begin
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (xfer) begin
      valid_d   = 1'b1;
      illegal_d = dec_illegal;
      in1_d     = dec_in1;
      in2_d     = dec_in2;
      sel_d     = dec_sel;
    end else if (valid_q && out_ready) begin
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      in1_q     <= '0;
      in2_q     <= '0;
      sel_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      sel_q     <= sel_d;
    end
  end

  assign out_valid = valid_q;
  assign illegal   = illegal_q;
  assign in1       = in1_q;
  assign in2       = in2_q;
  assign {sel5, sel4, sel3, sel2, sel1, sel0} = sel_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, corner sequences, random vs. reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [5:0]  opcode, func;
  logic [31:0] rs1_data, rs2_data;
  logic [15:0] imm16;
  logic        in_ready, out_valid, illegal;
  logic [31:0] in1, in2;
  logic        sel0, sel1, sel2, sel3, sel4, sel5;
  logic [5:0]  sel_bus;

  assign sel_bus = {sel5, sel4, sel3, sel2, sel1, sel0};

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func(func), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm16(imm16),
    .out_valid(out_valid), .out_ready(out_ready), .in1(in1), .in2(in2),
    .sel0(sel0), .sel1(sel1), .sel2(sel2), .sel3(sel3), .sel4(sel4), .sel5(sel5),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_valid, m_ill, m_known;
  logic [31:0] m_in1, m_in2;
  logic [5:0]  m_sel;

  string      rmap[int];
  string      imap[int];
  logic [5:0] selmap[string];

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] im;
    logic [31:0] e2;
    logic [5:0]  es;
    bit          eill;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [15:0] im, output logic [5:0] s,
                                     output logic [31:0] o1, output logic [31:0] o2,
                                     output bit ill);
    string n;
    if (op == 6'd0) n = rmap.exists(int'(fn)) ? rmap[int'(fn)] : "";
    else            n = imap.exists(int'(op)) ? imap[int'(op)] : "";
    if (n == "") begin
      ill = 1'b1; s = '0; o1 = '0; o2 = '0;
      return;
    end
    ill = 1'b0;
    s   = selmap[n];
    o1  = a;
    if (n == "SLL" || n == "SRL" || n == "SRA")
      o2 = ((op == 6'd0) ? b : 32'(im)) % 32;
    else if (op == 6'd0)
      o2 = b;
    else if (n == "AND" || n == "OR" || n == "XOR")
      o2 = 32'(im);
    else
      o2 = (im >= 16'h8000) ? 32'(im) + 32'hFFFF_0000 : 32'(im);
  endfunction

  task automatic setin(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] im, input logic v,
                       input logic ordy, input logic fl);
    opcode = op; func = fn; rs1_data = a; rs2_data = b; imm16 = im;
    in_valid = v; out_ready = ordy; flush = fl;
  endtask

  // One clock with model update; checks in_ready before the edge and all outputs after it.
  task automatic tick();
    bit          rdy, d_ill;
    logic [5:0]  d_sel;
    logic [31:0] d_in1, d_in2;
    #1;
    rdy = (!m_valid || out_ready) && !flush;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    ref_decode(opcode, func, rs1_data, rs2_data, imm16, d_sel, d_in1, d_in2, d_ill);
    @(posedge clk);
    #1;
    if (flush) begin
      m_valid = 1'b0; m_ill = 1'b0; m_known = 1'b0;
    end else if (in_valid && rdy) begin
      m_valid = 1'b1; m_ill = d_ill; m_sel = d_sel; m_in1 = d_in1; m_in2 = d_in2; m_known = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("illegal", 32'(illegal), 32'(m_ill));
    if (m_known) begin
      chk("in1", in1, m_in1);
      chk("in2", in2, m_in2);
      chk("sel", 32'(sel_bus), 32'(m_sel));
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_ill = 1'b0; m_known = 1'b1;
    m_in1 = '0; m_in2 = '0; m_sel = '0;
  endtask

  initial begin
    rmap[6'h20] = "ADD"; rmap[6'h21] = "ADD"; rmap[6'h22] = "SUB"; rmap[6'h23] = "SUB";
    rmap[6'h24] = "AND"; rmap[6'h25] = "OR";  rmap[6'h26] = "XOR"; rmap[6'h04] = "SLL";
    rmap[6'h06] = "SRL"; rmap[6'h07] = "SRA"; rmap[6'h28] = "SEQ"; rmap[6'h29] = "SNE";
    rmap[6'h2A] = "SLT"; rmap[6'h2B] = "SGT"; rmap[6'h2C] = "SLE"; rmap[6'h2D] = "SGE";
    imap[6'h08] = "ADD"; imap[6'h09] = "ADD"; imap[6'h0A] = "SUB"; imap[6'h0B] = "SUB";
    imap[6'h0C] = "AND"; imap[6'h0D] = "OR";  imap[6'h0E] = "XOR"; imap[6'h14] = "SLL";
    imap[6'h16] = "SRL"; imap[6'h17] = "SRA"; imap[6'h18] = "SEQ"; imap[6'h19] = "SNE";
    imap[6'h1A] = "SLT"; imap[6'h1B] = "SGT"; imap[6'h1C] = "SLE"; imap[6'h1D] = "SGE";
    selmap["AND"] = 6'b000000; selmap["OR"]  = 6'b000001; selmap["XOR"] = 6'b000010;
    selmap["SRA"] = 6'b000100; selmap["SRL"] = 6'b000101; selmap["SLL"] = 6'b000110;
    selmap["ADD"] = 6'b100000; selmap["SEQ"] = 6'b110000; selmap["SNE"] = 6'b110001;
    selmap["SLT"] = 6'b110010; selmap["SGT"] = 6'b110011; selmap["SLE"] = 6'b110100;
    selmap["SGE"] = 6'b110110; selmap["SUB"] = 6'b111000;

    //            op     fn     rs1            rs2            imm       exp in2        exp sel    ill
    tbl[0]  = '{6'h00, 6'h20, 32'd5,         32'd7,         16'h0000, 32'd7,         6'b100000, 1'b0};
    tbl[1]  = '{6'h0C, 6'h00, 32'h0000_1234, 32'h0,         16'h8001, 32'h0000_8001, 6'b000000, 1'b0};
    tbl[2]  = '{6'h1A, 6'h00, 32'h0000_0042, 32'h0,         16'h8001, 32'hFFFF_8001, 6'b110010, 1'b0};
    tbl[3]  = '{6'h00, 6'h04, 32'h0000_00FF, 32'h0000_0123, 16'h0000, 32'h0000_0003, 6'b000110, 1'b0};
    tbl[4]  = '{6'h3F, 6'h00, 32'hAAAA_AAAA, 32'h5555_5555, 16'h1234, 32'h0,         6'b000000, 1'b1};
    tbl[5]  = '{6'h17, 6'h00, 32'h8000_0000, 32'h0,         16'hFFFF, 32'h0000_001F, 6'b000100, 1'b0};
    tbl[6]  = '{6'h0E, 6'h00, 32'h1111_1111, 32'h0,         16'hF00F, 32'h0000_F00F, 6'b000010, 1'b0};
    tbl[7]  = '{6'h00, 6'h23, 32'h0000_0009, 32'hDEAD_BEEF, 16'h0000, 32'hDEAD_BEEF, 6'b111000, 1'b0};
    tbl[8]  = '{6'h1D, 6'h00, 32'h0000_0001, 32'h0,         16'h7FFF, 32'h0000_7FFF, 6'b110110, 1'b0};
    tbl[9]  = '{6'h00, 6'h01, 32'h1234_5678, 32'h8765_4321, 16'h0000, 32'h0,         6'b000000, 1'b1};
    tbl[10] = '{6'h0B, 6'h00, 32'h0000_0010, 32'h0,         16'hFFFE, 32'hFFFF_FFFE, 6'b111000, 1'b0};
    tbl[11] = '{6'h00, 6'h06, 32'hF000_0000, 32'hFFFF_FFFF, 16'h0000, 32'h0000_001F, 6'b000101, 1'b0};
    tbl[12] = '{6'h1C, 6'h00, 32'h0000_0003, 32'h0,         16'h8000, 32'hFFFF_8000, 6'b110100, 1'b0};
    tbl[13] = '{6'h00, 6'h25, 32'h0F0F_0F0F, 32'hF0F0_0000, 16'h0000, 32'hF0F0_0000, 6'b000001, 1'b0};
    tbl[14] = '{6'h09, 6'h00, 32'h0000_0100, 32'h0,         16'h0010, 32'h0000_0010, 6'b100000, 1'b0};
    tbl[15] = '{6'h00, 6'h2B, 32'hFFFF_FFFF, 32'h0000_0001, 16'h0000, 32'h0000_0001, 6'b110011, 1'b0};

    rst_n = 1'b0;
    setin(6'h00, 6'h20, 32'h0, 32'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_in1", in1, 32'd0);
    chk("rst_in2", in2, 32'd0);
    chk("rst_sel", 32'(sel_bus), 32'd0);
    model_reset();

    // Release between edges; the very next posedge must already accept the first vector.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      setin(tbl[i].op, tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].im, 1'b1, 1'b1, 1'b0);
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_in1", i), in1, tbl[i].eill ? 32'd0 : tbl[i].a);
      chk($sformatf("vec%0d_in2", i), in2, tbl[i].e2);
      chk($sformatf("vec%0d_sel", i), 32'(sel_bus), 32'(tbl[i].es));
      chk($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(tbl[i].eill));
    end

    // Stall: three cycles with a waiting instruction, then release.
    setin(6'h00, 6'h20, 32'd11, 32'd22, 16'h0, 1'b1, 1'b1, 1'b0);
    tick();
    setin(6'h00, 6'h22, 32'd33, 32'd44, 16'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_in1", in1, 32'd11);
      chk("stall_sel", 32'(sel_bus), 32'b100000);
    end
    out_ready = 1'b1;
    tick();
    chk("unstall_in1", in1, 32'd33);
    chk("unstall_sel", 32'(sel_bus), 32'b111000);

    // Drain: consumed with nothing behind it, payload holds.
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_in2", in2, 32'd44);

    // Illegal entry, then flush racing a new instruction.
    setin(6'h3F, 6'h00, 32'h1, 32'h2, 16'h3, 1'b1, 1'b1, 1'b0);
    tick();
    chk("illop_illegal", 32'(illegal), 32'd1);
    chk("illop_sel", 32'(sel_bus), 32'd0);
    setin(6'h00, 6'h20, 32'd1, 32'd2, 16'h0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_illegal", 32'(illegal), 32'd0);
    flush = 1'b0;

    // Asynchronous reset in the middle of a stall.
    setin(6'h00, 6'h21, 32'h55, 32'h66, 16'h0, 1'b1, 1'b1, 1'b0);
    tick();
    out_ready = 1'b0;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in1", in1, 32'd0);
    chk("mid_rst_in2", in2, 32'd0);
    chk("mid_rst_sel", 32'(sel_bus), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    setin(6'h0D, 6'h00, 32'h77, 32'h0, 16'h8888, 1'b1, 1'b1, 1'b0);
    tick();
    chk("post_rst_in2", in2, 32'h0000_8888);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom_range(0, 63));
      fn = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(32'h20, 32'h2D)) : 6'($urandom_range(0, 63));
      setin(op, fn, $urandom, $urandom, 16'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
